seg7_capture: RTL and testbench

Multiplexed seven-segment display monitor: it samples the active-low anode and segment lines that drive a scanned display and reconstructs the hex value shown on each digit. It applies the inverse of the team's hex-to-segment decode table. The block sits on the display side of the board-level logic and serves as a self-check and readback path: digit values come out as nibbles, with per-digit valid and error flags. Each sample is filtered for stability before it is committed, so scan transitions and ghosting do not produce false updates.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_encoder.sv | 24 ++
 rtl/seg7_capture.sv | 140 ++++++++++++++
 tb/tb_seg7_capture.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment capture path.
// Segment vectors are active-low, bit6=a ... bit0=g.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG7_BLANK = 7'h7F;

  localparam seg_t SEG7_HEX [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic [1:0] {IDLE, TRACK, HELD} trk_state_e;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational inverse of the hex-to-segment table.
// Classifies a segment pattern as hex (with nibble), blank or neither.
module seg7_encoder
  import seg7_pkg::*;
(
  input  seg_t       seg,
  output logic       is_hex,
  output logic       is_blank,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_HEX[i]) begin
        is_hex = 1'b1;
        nibble = 4'(i);
      end
    end
    is_blank = (seg == SEG7_BLANK);
  end

endmodule

// File: rtl/seg7_capture.sv
// Scanned seven-segment display monitor: filters each anode/segment sample
// for stability and reconstructs per-digit hex values with valid/error flags.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en_i,
  input  logic [NUM_DIGITS-1:0]   an_i,
  input  logic [6:0]              seg_i,
  input  logic                    clear_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic [NUM_DIGITS-1:0]   err_o,
  output logic                    update_o
);

  localparam int unsigned CW = $clog2(STABLE_CNT + 1);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

  trk_state_e      state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IW-1:0]   sel_idx, sel_d;
  seg_t            last_pat, pat_d;

  logic [NUM_DIGITS-1:0]   low_c;
  logic                    one_hot_c;
  logic [IW-1:0]           idx_c;
  logic                    commit_c;
  logic                    is_hex_c, is_blank_c;
  logic [3:0]              nibble_c;
  logic [4*NUM_DIGITS-1:0] digits_d;
  logic [NUM_DIGITS-1:0]   valid_d, err_d;
  logic                    update_d;

  seg7_encoder u_enc (
    .seg      (seg_i),
    .is_hex   (is_hex_c),
    .is_blank (is_blank_c),
    .nibble   (nibble_c)
  );

  // Exactly one anode low selects a digit; anything else is a scan gap.
  always_comb begin
    low_c     = ~an_i;
    one_hot_c = (low_c != '0) && ((low_c & (low_c - NUM_DIGITS'(1))) == '0);
    idx_c     = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (low_c[i]) idx_c = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sel_idx  <= '0;
      last_pat <= SEG7_BLANK;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      sel_idx  <= sel_d;
      last_pat <= pat_d;
    end
  end

  // Stability tracker; commit fires only on the sample that reaches CNT_MAX.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sel_d    = sel_idx;
    pat_d    = last_pat;
    commit_c = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = '0;
      pat_d   = SEG7_BLANK;
    end else if (sample_en_i) begin
      if (!one_hot_c) begin
        cnt_d = '0;
      end else if (idx_c == sel_idx && seg_i == last_pat) begin
        if (state != HELD) begin
          cnt_d    = cnt + CW'(1);
          commit_c = (cnt_d == CNT_MAX);
        end
      end else begin
        sel_d    = idx_c;
        pat_d    = seg_i;
        cnt_d    = CW'(1);
        commit_c = (CNT_MAX == CW'(1));
      end
      if (cnt_d == '0)          state_d = IDLE;
      else if (cnt_d == CNT_MAX) state_d = HELD;
      else                      state_d = TRACK;
    end
  end

  // Commit into the per-digit output image; pulse only on a visible change.
  always_comb begin
    digits_d = digits_o;
    valid_d  = valid_o;
    err_d    = err_o;
    update_d = 1'b0;
    if (clear_i) begin
      digits_d = '0;
      valid_d  = '0;
      err_d    = '0;
    end else if (commit_c) begin
      if (is_hex_c) begin
        digits_d[{idx_c, 2'b00} +: 4] = nibble_c;
        valid_d[idx_c]                = 1'b1;
      end else if (is_blank_c) begin
        valid_d[idx_c] = 1'b0;
      end else begin
        err_d[idx_c] = 1'b1;
      end
      update_d = (digits_d != digits_o) || (valid_d != valid_o);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_o <= '0;
      valid_o  <= '0;
      err_o    <= '0;
      update_o <= 1'b0;
    end else begin
      digits_o <= digits_d;
      valid_o  <= valid_d;
      err_o    <= err_d;
      update_o <= update_d;
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with a spec-level reference model and
// an expected-output queue checked one clock after each driven sample.
module tb_seg7_capture;

  localparam int ND = 8;
  localparam int SC = 4;

  localparam logic [6:0] HEXTAB [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef struct packed {
    logic [31:0] dig;
    logic [7:0]  val;
    logic [7:0]  err;
    logic        upd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en_i;
  logic [7:0]  an_i;
  logic [6:0]  seg_i;
  logic        clear_i;
  logic [31:0] digits_o;
  logic [7:0]  valid_o;
  logic [7:0]  err_o;
  logic        update_o;

  int tests = 0;
  int fails = 0;
  int upd_seen = 0;
  int saw8 = 0;

  exp_t sb[$];

  // reference model state
  logic [31:0] m_dig;
  logic [7:0]  m_val, m_err;
  int          m_sel, m_cnt;
  logic [6:0]  m_pat;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en_i (sample_en_i),
    .an_i        (an_i),
    .seg_i       (seg_i),
    .clear_i     (clear_i),
    .digits_o    (digits_o),
    .valid_o     (valid_o),
    .err_o       (err_o),
    .update_o    (update_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dig = '0; m_val = '0; m_err = '0;
    m_sel = 0; m_cnt = 0; m_pat = 7'h7F;
  endtask

  task automatic step(input string tag, input logic en, input logic [7:0] an,
                      input logic [6:0] seg, input logic clr);
    exp_t e, got;
    int   nz, k, nib;
    logic hit;
    logic [31:0] pd;
    logic [7:0]  pv;
    sample_en_i = en; an_i = an; seg_i = seg; clear_i = clr;
    e.upd = 1'b0;
    if (clr) begin
      model_reset();
    end else if (en) begin
      nz = 0; k = 0;
      for (int i = 0; i < ND; i++) if (!an[i]) begin nz++; k = i; end
      if (nz != 1) begin
        m_cnt = 0;
      end else begin
        hit = 1'b0;
        if (k == m_sel && seg == m_pat) begin
          if (m_cnt < SC) begin m_cnt++; hit = (m_cnt == SC); end
        end else begin
          m_sel = k; m_pat = seg; m_cnt = 1; hit = (SC == 1);
        end
        if (hit) begin
          pd = m_dig; pv = m_val; nib = -1;
          for (int h = 0; h < 16; h++) if (HEXTAB[h] == seg) nib = h;
          if (nib >= 0) begin
            m_dig[4*k +: 4] = 4'(nib);
            m_val[k] = 1'b1;
          end else if (seg == 7'h7F) begin
            m_val[k] = 1'b0;
          end else begin
            m_err[k] = 1'b1;
          end
          e.upd = (pd != m_dig) || (pv != m_val);
        end
      end
    end
    e.dig = m_dig; e.val = m_val; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, "/digits"}, digits_o, got.dig);
      chk({tag, "/valid"}, 32'(valid_o), 32'(got.val));
      chk({tag, "/err"}, 32'(err_o), 32'(got.err));
      chk({tag, "/update"}, 32'(update_o), 32'(got.upd));
    end
    if (update_o) upd_seen++;
    if (valid_o[0] && digits_o[3:0] == 4'h8) saw8++;
  endtask

  initial begin
    int u0;
    rst_n = 1'b0; sample_en_i = 1'b0; an_i = 8'hFF; seg_i = 7'h7F; clear_i = 1'b0;
    model_reset();
    #12;
    chk("reset/digits", digits_o, 32'd0);
    chk("reset/flags", {16'd0, valid_o, err_o}, 32'd0);
    chk("reset/update", 32'(update_o), 32'd0);
    rst_n = 1'b1;

    // hex capture on digit 2, with idle strobes mixed in
    u0 = upd_seen;
    step("cap", 1'b1, 8'hFB, 7'h12, 1'b0);
    step("cap_idle", 1'b0, 8'hFF, 7'h00, 1'b0);
    step("cap", 1'b1, 8'hFB, 7'h12, 1'b0);
    step("cap", 1'b1, 8'hFB, 7'h12, 1'b0);
    chk("cap/not_yet", 32'(valid_o), 32'h00);
    step("cap", 1'b1, 8'hFB, 7'h12, 1'b0);
    chk("cap/nibble2", 32'(digits_o[11:8]), 32'h2);
    chk("cap/valid", 32'(valid_o), 32'h04);
    chk("cap/pulses", upd_seen - u0, 1);

    u0 = upd_seen;
    for (int i = 0; i < 10; i++) step("hold", 1'b1, 8'hFB, 7'h12, 1'b0);
    chk("hold/pulses", upd_seen - u0, 0);
    chk("hold/digits", digits_o, 32'h0000_0200);

    // ghost of an 8 before a real 6 on digit 0
    u0 = upd_seen;
    for (int i = 0; i < 3; i++) step("ghost", 1'b1, 8'hFE, 7'h00, 1'b0);
    for (int i = 0; i < 4; i++) step("six", 1'b1, 8'hFE, 7'h20, 1'b0);
    chk("glitch/digit0", 32'(digits_o[3:0]), 32'h6);
    chk("glitch/pulses", upd_seen - u0, 1);
    chk("glitch/no8", saw8, 0);

    // digit 7: F, then invalid, then blank
    for (int i = 0; i < 4; i++) step("d7_F", 1'b1, 8'h7F, 7'h38, 1'b0);
    chk("d7/valid", 32'(valid_o), 32'h85);
    for (int i = 0; i < 4; i++) step("d7_bad", 1'b1, 8'h7F, 7'h7E, 1'b0);
    chk("d7/err", 32'(err_o), 32'h80);
    chk("d7/valid_kept", 32'(valid_o), 32'h85);
    for (int i = 0; i < 4; i++) step("d7_blank", 1'b1, 8'h7F, 7'h7F, 1'b0);
    chk("d7/blanked", 32'(valid_o), 32'h05);
    chk("d7/nibble_kept", 32'(digits_o[31:28]), 32'hF);

    // illegal selects every third strobe keep restarting the count
    for (int i = 0; i < 12; i++)
      step("illegal", 1'b1, (i % 3 == 2) ? ((i % 2 == 0) ? 8'hFC : 8'hFF) : 8'hFD,
           7'h4F, 1'b0);
    chk("illegal/no_commit", 32'(valid_o[1]), 32'd0);

    // clear wins over a committing sample
    for (int i = 0; i < 3; i++) step("pre_clr", 1'b1, 8'hEF, 7'h04, 1'b0);
    step("clr", 1'b1, 8'hEF, 7'h04, 1'b1);
    chk("clr/all", {digits_o[23:0], valid_o}, 32'd0);
    chk("clr/err", 32'(err_o), 32'd0);

    // async reset mid-track discards the partial count
    for (int i = 0; i < 4; i++) step("d4_9", 1'b1, 8'hEF, 7'h04, 1'b0);
    chk("d4/valid", 32'(valid_o), 32'h10);
    step("mid", 1'b1, 8'hFE, 7'h4F, 1'b0);
    step("mid", 1'b1, 8'hFE, 7'h4F, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst/digits", digits_o, 32'd0);
    chk("rst/valid", 32'(valid_o), 32'd0);
    model_reset();
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst", 1'b1, 8'hFE, 7'h4F, 1'b0);
    chk("post_rst/none", 32'(valid_o), 32'd0);
    step("post_rst", 1'b1, 8'hFE, 7'h4F, 1'b0);
    chk("post_rst/commit", {24'd0, valid_o}, 32'h01);
    chk("post_rst/nibble", 32'(digits_o[3:0]), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
